// File: rtl/seq_match_pkg.sv
// Shared types and reset defaults for the serial pattern-match run controller.
package seq_match_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OVERLAP_RST = 1'b1;
    localparam int   TARGET_RST  = 0;

endpackage

// File: rtl/seq_match_ctrl_if.sv
// Config handshake, serial stream and status bundle between a config master and the match controller.
interface seq_match_ctrl_if #(
    parameter int PAT_W = seq_match_pkg::PAT_W_DEF,
    parameter int CNT_W = seq_match_pkg::CNT_W_DEF
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [CNT_W-1:0] cfg_target;
    logic             cfg_overlap;
    logic             start;
    logic             abort;
    logic             in_valid;
    logic             in;
    logic             busy;
    logic             match;
    logic             done;
    logic [CNT_W-1:0] match_count;

    modport master (
        output cfg_valid, cfg_pattern, cfg_target, cfg_overlap, start, abort, in_valid, in,
        input  cfg_ready, busy, match, done, match_count
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_target, cfg_overlap, start, abort, in_valid, in,
        output cfg_ready, busy, match, done, match_count
    );
endinterface

// File: rtl/seq_window.sv
// PAT_W-bit shift window with saturating fill count; hit is combinational on the incoming bit.
// Zero latency on hit; no backpressure, one bit accepted per shift_en.
module seq_window #(
    parameter int PAT_W = seq_match_pkg::PAT_W_DEF
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             shift_en,
    input  logic             flush,
    input  logic             bit_in,
    input  logic             overlap,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit
);
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  win;
    logic [PAT_W-1:0]  win_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;

    always_comb begin
        win_nxt  = {win[PAT_W-2:0], bit_in};
        fill_nxt = (fill == FULL) ? FULL : fill + 1'b1;
        hit      = shift_en && (fill_nxt == FULL) && (win_nxt == pattern);
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            win  <= '0;
            fill <= '0;
        end else if (flush) begin
            win  <= '0;
            fill <= '0;
        end else if (shift_en) begin
            win  <= win_nxt;
            // Non-overlapping mode needs a full fresh window before the next hit.
            fill <= (hit && !overlap) ? '0 : fill_nxt;
        end
    end
endmodule

// File: rtl/seq_match_ctrl.sv
// Run controller for the serial pattern detector: config load, start/abort, match counting, target stop.
// match/done are registered (1 cycle after the sampling edge); config is accepted only in IDLE.
module seq_match_ctrl
    import seq_match_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            clear_n,
    seq_match_ctrl_if.slave bus
);
    state_t           state;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] target;
    logic             overlap;
    logic             busy_q;
    logic             match_q;
    logic             done_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_inc;
    logic             shift_en;
    logic             flush;
    logic             hit;

    // Abort wins over a same-edge bit, so the bit never reaches the window.
    assign shift_en  = (state == RUN) && bus.in_valid && !bus.abort;
    assign flush     = (state == IDLE) && bus.start && !bus.abort;
    assign count_inc = (count_q == '1) ? count_q : count_q + 1'b1;

    seq_window #(.PAT_W(PAT_W)) u_window (
        .clk      (clk),
        .clear_n  (clear_n),
        .shift_en (shift_en),
        .flush    (flush),
        .bit_in   (bus.in),
        .overlap  (overlap),
        .pattern  (pattern),
        .hit      (hit)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state   <= IDLE;
            pattern <= '0;
            target  <= CNT_W'(TARGET_RST);
            overlap <= OVERLAP_RST;
            busy_q  <= 1'b0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            match_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cfg_valid) begin
                        pattern <= bus.cfg_pattern;
                        target  <= bus.cfg_target;
                        overlap <= bus.cfg_overlap;
                    end
                    if (flush) begin
                        state   <= RUN;
                        busy_q  <= 1'b1;
                        count_q <= '0;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (hit) begin
                        match_q <= 1'b1;
                        count_q <= count_inc;
                        if ((target != '0) && (count_inc == target)) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cfg_ready   = (state == IDLE);
    assign bus.busy        = busy_q;
    assign bus.match       = match_q;
    assign bus.done        = done_q;
    assign bus.match_count = count_q;
endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed scenarios for seq_match_ctrl; expected pulses are queued by the stimulus, checked by a monitor.
module tb_seq_match_ctrl;
    localparam int PW = 4;
    localparam int CW = 8;

    typedef struct {
        int cyc;
        bit done;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic clear_n = 1'b0;
    always #5 clk = ~clk;

    seq_match_ctrl_if #(.PAT_W(PW), .CNT_W(CW)) bus ();

    seq_match_ctrl #(.PAT_W(PW), .CNT_W(CW)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    int   run_cnt = 0;
    exp_t q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: every match/done pulse must correspond to a queued expectation.
    always @(posedge clk) begin
        #1;
        if (bus.match || bus.done) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, bus.match, bus.done}, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_match", int'(bus.match), 1);
                chk("pulse_done", int'(bus.done), int'(e.done));
                chk("pulse_count", int'(bus.match_count), e.cnt);
            end
        end
    end

    // All tasks start and end at a falling edge.
    task automatic do_start(input logic load, input logic [PW-1:0] pat,
                            input logic [CW-1:0] tgt, input logic ov);
        bus.cfg_valid   = load;
        bus.cfg_pattern = pat;
        bus.cfg_target  = tgt;
        bus.cfg_overlap = ov;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        bus.start     = 1'b0;
        run_cnt       = 0;
        chk("busy_after_start", int'(bus.busy), 1);
        chk("cfg_ready_in_run", int'(bus.cfg_ready), 0);
        chk("count_cleared", int'(bus.match_count), 0);
    endtask

    task automatic send_bit(input logic b, input bit m, input bit d);
        bus.in       = b;
        bus.in_valid = 1'b1;
        if (m) begin
            run_cnt++;
            q.push_back('{cyc + 1, d, run_cnt});
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_bits(input logic [15:0] bits, input int n,
                            input logic [15:0] mask, input int done_at);
        for (int i = 1; i <= n; i++)
            send_bit(bits[n-i], mask[n-i], i == done_at);
    endtask

    task automatic end_run(input string tag, input int exp_cnt);
        repeat (2) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        @(negedge clk);
        chk({tag, "_count"}, int'(bus.match_count), exp_cnt);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_cfg_ready"}, int'(bus.cfg_ready), 1);
        chk({tag, "_missing_pulses"}, q.size(), 0);
    endtask

    initial begin
        bus.cfg_valid = 0; bus.cfg_pattern = '0; bus.cfg_target = '0; bus.cfg_overlap = 0;
        bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.in = 0;
        #3;
        chk("rst_match", int'(bus.match), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_count", int'(bus.match_count), 0);
        chk("rst_cfg_ready", int'(bus.cfg_ready), 1);
        #9 clear_n = 1'b1;
        @(negedge clk);

        // 1: overlapping, unlimited
        do_start(1, 4'b1011, 8'd0, 1);
        run_bits(16'b10110101011, 11, 16'b00010000001, 0);
        end_run("t1", 2);

        // 2: overlap vs non-overlap
        do_start(1, 4'b1011, 8'd0, 1);
        run_bits(16'b1011011, 7, 16'b0001001, 0);
        end_run("t2_ov", 2);
        do_start(1, 4'b1011, 8'd0, 0);
        run_bits(16'b1011011, 7, 16'b0001000, 0);
        end_run("t2_nov", 1);

        // 3: target 1 stops the run; abort afterwards lands in IDLE and changes nothing
        do_start(1, 4'b1011, 8'd1, 1);
        run_bits(16'b10111011, 8, 16'b00010000, 4);
        chk("t3_busy_after_done", int'(bus.busy), 0);
        chk("t3_cfg_ready", int'(bus.cfg_ready), 1);
        end_run("t3", 1);

        // 4: in_valid gaps hold the window
        do_start(1, 4'b1011, 8'd0, 1);
        send_bit(1, 0, 0);
        send_bit(0, 0, 0);
        repeat (3) @(negedge clk);
        send_bit(1, 0, 0);
        send_bit(1, 1, 0);
        end_run("t4", 1);

        // 5: abort on the completing bit, with a simultaneous start
        do_start(1, 4'b1011, 8'd0, 1);
        run_bits(16'b101, 3, 16'b0, 0);
        bus.in = 1; bus.in_valid = 1; bus.abort = 1; bus.start = 1;
        @(negedge clk);
        bus.in_valid = 0; bus.abort = 0; bus.start = 0;
        chk("t5_busy", int'(bus.busy), 0);
        chk("t5_count", int'(bus.match_count), 0);
        chk("t5_cfg_ready", int'(bus.cfg_ready), 1);
        repeat (3) @(negedge clk);
        chk("t5_start_ignored", int'(bus.busy), 0);
        chk("t5_missing_pulses", q.size(), 0);

        // 6: asynchronous reset mid-run, right after a match pulse appears
        do_start(1, 4'b1011, 8'd0, 1);
        run_bits(16'b1011101, 7, 16'b0001000, 0);
        bus.in = 1; bus.in_valid = 1;
        run_cnt++;
        q.push_back('{cyc + 1, 1'b0, run_cnt});
        @(posedge clk);
        #3 clear_n = 1'b0;
        #1;
        chk("t6_match", int'(bus.match), 0);
        chk("t6_done", int'(bus.done), 0);
        chk("t6_busy", int'(bus.busy), 0);
        chk("t6_count", int'(bus.match_count), 0);
        @(negedge clk);
        bus.in_valid = 0;
        #2 clear_n = 1'b1;
        #1 chk("t6_cfg_ready", int'(bus.cfg_ready), 1);
        @(negedge clk);
        // Defaults after reset: pattern 0000, overlap on, unlimited target.
        do_start(0, 4'b1111, 8'd1, 0);
        run_bits(16'b00000, 5, 16'b00011, 0);
        end_run("t6_defaults", 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
